// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - op codes, FSM states and sign-magnitude helpers for seq_alu
package seq_alu_pkg;

  localparam logic [2:0] OP_PASS   = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_POPCNT = 3'd3;
  localparam logic [2:0] OP_SHIFT  = 3'd4;
  localparam logic [2:0] OP_MEDIAN = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Helpers work on 64-bit values so they serve any legal W up to 32.
  function automatic logic signed [63:0] sm_to_tc(input logic s, input logic [63:0] m);
    return s ? -$signed(m) : $signed(m);
  endfunction

  function automatic logic tc_sign(input logic signed [63:0] v);
    return v[63];
  endfunction

  function automatic logic [63:0] tc_mag(input logic signed [63:0] v);
    return v[63] ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response handshake bundle for seq_alu
interface seq_alu_if #(parameter int W = 4);
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic           a_sign;
  logic [W-1:0]   a_mag;
  logic           b_sign;
  logic [W-1:0]   b_mag;
  logic           out_valid;
  logic           out_ready;
  logic           res_sign;
  logic [2*W-1:0] res_mag;
  logic           err;

  modport master (
    output in_valid, op, a_sign, a_mag, b_sign, b_mag, out_ready,
    input  in_ready, out_valid, res_sign, res_mag, err
  );

  modport slave (
    input  in_valid, op, a_sign, a_mag, b_sign, b_mag, out_ready,
    output in_ready, out_valid, res_sign, res_mag, err
  );
endinterface

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - shift-add multiplier, one multiplier bit per edge, W-edge latency
module seq_alu_mul #(
  parameter int W     = 4,
  parameter int CNT_W = $clog2(W+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;

  // The start edge already folds in bit 0, so W-1 further edges finish the job.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = (cnt == CNT_W'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= b[0] ? {{W{1'b0}}, a} : '0;
      mcand  <= {{W{1'b0}}, a} << 1;
      mplier <= b >> 1;
      cnt    <= CNT_W'(1);
    end else if (cnt != '0) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered sign-magnitude ALU with handshake and iterative multiply
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = $clog2(W+1)
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  state_t state, next_state;

  logic           res_sign;
  logic [2*W-1:0] res_mag;
  logic           err;
  logic           mul_sign;
  logic           mul_done;
  logic [2*W-1:0] mul_product;
  logic           accept;

  logic           nx_sign;
  logic [2*W-1:0] nx_mag;
  logic           nx_err;
  logic signed [63:0] add_sum;
  logic [W-1:0]   sh;
  logic [W-1:0]   med;

  assign accept        = (state == IDLE) && bus.in_valid;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.res_sign  = res_sign;
  assign bus.res_mag   = res_mag;
  assign bus.err       = err;

  seq_alu_mul #(.W(W), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && (bus.op == OP_MUL)),
    .a       (bus.a_mag),
    .b       (bus.b_mag),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.in_valid) next_state = (bus.op == OP_MUL) ? CALC : DONE;
      CALC: if (mul_done) next_state = DONE;
      DONE: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    nx_sign = 1'b0;
    nx_mag  = '0;
    nx_err  = 1'b0;
    add_sum = sm_to_tc(bus.a_sign, 64'(bus.a_mag)) + sm_to_tc(bus.b_sign, 64'(bus.b_mag));
    sh      = bus.a_sign ? (bus.a_mag << bus.b_mag) : (bus.a_mag >> bus.b_mag);
    med     = '0;
    for (int i = 0; i < W; i++) begin
      med[i] = (bus.a_mag[i] & bus.a_mag[(i+1)%W]) | (bus.a_mag[i] & bus.a_mag[(i+2)%W]) |
               (bus.a_mag[(i+1)%W] & bus.a_mag[(i+2)%W]);
    end
    case (bus.op)
      OP_PASS: begin
        nx_sign = bus.a_sign;
        nx_mag  = (2*W)'(bus.a_mag);
      end
      OP_ADD: begin
        nx_sign = tc_sign(add_sum);
        nx_mag  = (2*W)'(tc_mag(add_sum));
      end
      OP_POPCNT: begin
        for (int i = 0; i < W; i++) nx_mag = nx_mag + (2*W)'(bus.a_mag[i]);
      end
      OP_SHIFT:  nx_mag = (2*W)'(sh);
      OP_MEDIAN: nx_mag = (2*W)'(med);
      default:   nx_err = 1'b1;
    endcase
    // Negative zero is never presented downstream.
    nx_sign = nx_sign & (nx_mag != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      res_sign <= 1'b0;
      res_mag  <= '0;
      err      <= 1'b0;
      mul_sign <= 1'b0;
    end else begin
      state <= next_state;
      if (accept && (bus.op != OP_MUL)) begin
        res_sign <= nx_sign;
        res_mag  <= nx_mag;
        err      <= nx_err;
      end
      if (accept && (bus.op == OP_MUL)) mul_sign <= bus.a_sign ^ bus.b_sign;
      if ((state == CALC) && mul_done) begin
        res_sign <= mul_sign & (mul_product != '0);
        res_mag  <= mul_product;
        err      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.W(4)) bus ();
  seq_alu_if #(.W(8)) bus8 ();

  seq_alu #(.W(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  seq_alu #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic       s;
    logic [7:0] m;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  function automatic exp_t model(input int op, input int as, input int am, input int bs, input int bm);
    exp_t e;
    int va, vb, r, votes;
    e.s = 1'b0;
    e.e = 1'b0;
    r   = 0;
    case (op)
      0: begin r = am; e.s = as[0]; end
      1: begin
        va = as ? -am : am;
        vb = bs ? -bm : bm;
        r  = va + vb;
        e.s = (r < 0);
        if (r < 0) r = -r;
      end
      2: begin r = am * bm; e.s = as[0] ^ bs[0]; end
      3: r = $countones(am);
      4: r = as ? ((am << bm) % 16) : (am >> bm);
      5: for (int i = 0; i < 4; i++) begin
           votes = ((am >> i) & 1) + ((am >> ((i+1)%4)) & 1) + ((am >> ((i+2)%4)) & 1);
           if (votes >= 2) r += (1 << i);
         end
      default: e.e = 1'b1;
    endcase
    if (r == 0) e.s = 1'b0;
    e.m = 8'(r);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        check("res_sign", bus.res_sign, e.s);
        check("res_mag", bus.res_mag, e.m);
        check("err", bus.err, e.e);
      end
    end
  end

  task automatic do_txn(input int op, input int as, input int am, input int bs, input int bm, input int hold);
    exp_t e;
    int n, lat;
    e = model(op, as, am, bs, bm);
    bus.op = op[2:0]; bus.a_sign = as[0]; bus.a_mag = am[3:0];
    bus.b_sign = bs[0]; bus.b_mag = bm[3:0]; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) check("accept_timeout", 0, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    // Keep a live, changing request on the bus while busy: it must be ignored.
    bus.op = 3'($urandom); bus.a_sign = 1'($urandom); bus.a_mag = 4'($urandom);
    bus.b_sign = 1'($urandom); bus.b_mag = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) check("in_ready_busy", bus.in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (op == 2) ? 4 : 1);
    for (int h = 0; h < hold; h++) begin
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_res_mag", bus.res_mag, e.m);
      check("hold_res_sign", bus.res_sign, e.s);
      check("hold_err", bus.err, e.e);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    int lat;
    bus.in_valid = 0; bus.op = 0; bus.a_sign = 0; bus.a_mag = 0;
    bus.b_sign = 0; bus.b_mag = 0; bus.out_ready = 0;
    bus8.in_valid = 0; bus8.op = 0; bus8.a_sign = 0; bus8.a_mag = 0;
    bus8.b_sign = 0; bus8.b_mag = 0; bus8.out_ready = 0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_res_sign", bus.res_sign, 0);
    check("rst_res_mag", bus.res_mag, 0);
    check("rst_err", bus.err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_txn(1, 1, 3, 0, 5, 0);
    do_txn(1, 1, 5, 0, 5, 0);
    do_txn(2, 1, 7, 0, 0, 0);
    do_txn(2, 1, 15, 0, 15, 1);
    do_txn(4, 1, 11, 0, 2, 0);
    do_txn(4, 0, 13, 0, 5, 0);
    do_txn(5, 0, 6, 0, 0, 0);
    do_txn(3, 0, 11, 0, 0, 0);
    do_txn(1, 0, 9, 1, 2, 3);
    do_txn(7, 1, 9, 1, 4, 0);
    do_txn(0, 1, 0, 0, 3, 0);

    for (int i = 0; i < 30; i++)
      do_txn($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 2));

    // Abort a multiply on its second CALC cycle.
    bus.op = 3'd2; bus.a_sign = 1; bus.a_mag = 4'd13; bus.b_sign = 0; bus.b_mag = 4'd11;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_res_mag", bus.res_mag, 0);
    check("abort_res_sign", bus.res_sign, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_txn(2, 0, 3, 0, 3, 0);

    bus8.op = 3'd2; bus8.a_mag = 8'd255; bus8.b_mag = 8'd255; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("w8_latency", lat, 8);
    check("w8_res_mag", bus8.res_mag, 65025);
    check("w8_res_sign", bus8.res_sign, 0);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check("w8_in_ready", bus8.in_ready, 1);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
